// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and frame state encoding for the transmit and receive paths
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between the requester and the UART transmitter
interface uart_tx_if;
  import uart_pkg::*;
  logic [DATA_W-1:0] txData;
  logic txValid;
  logic txReady;
  modport master(output txData, output txValid, input txReady);
  modport slave(input txData, input txValid, output txReady);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit cycle counter with clear/enable, pulses bit_done on the last cycle of each bit
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic bit_done
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] cnt;
  assign bit_done = en && cnt == W'(CLKS_PER_BIT - 1);
  // count 0..CLKS_PER_BIT-1 while enabled, wrapping on each bit boundary
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= bit_done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     rstn,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy
);
  uart_state_t state;
  logic [DATA_W-1:0] shift;
  logic [2:0] idx;
  logic rdy, accept, bit_done;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  assign bus.txReady = rdy;
  assign accept = bus.txValid && rdy;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rstn(rstn),
    .clr(accept),
    .en(busy),
    .bit_done(bit_done)
  );
  // frame sequencer; tx, txReady and busy are registered so the line never sees input glitches
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      tx <= UART_IDLE_LEVEL;
      rdy <= 1'b1;
      busy <= 1'b0;
      shift <= '0;
      idx <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (accept) begin
          state <= START;
          shift <= bus.txData;
          idx <= '0;
          tx <= 1'b0;
          rdy <= 1'b0;
          busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
          par <= ^bus.txData;
`endif
        end
        START: if (bit_done) begin
          state <= DATA;
          tx <= shift[0];
        end
        DATA: if (bit_done) begin
          shift <= shift >> 1;
          idx <= idx + 3'd1;
          if (idx == 3'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx <= par;
`else
            state <= STOP;
            tx <= UART_IDLE_LEVEL;
`endif
          end else tx <= shift[1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_done) begin
          state <= STOP;
          tx <= UART_IDLE_LEVEL;
        end
`endif
        STOP: if (bit_done) begin
          state <= IDLE;
          rdy <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tx <= UART_IDLE_LEVEL;
          rdy <= 1'b1;
          busy <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at CLKS_PER_BIT=4 (UART_TX_PARITY_EN aware)
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L = NB * CPB;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tx, busy;
  int checks = 0;
  int failures = 0;
  uart_tx_if bus();
  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .tx(tx),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_tx"}, 32'(tx), 32'd1);
    chk({tag, "_rdy"}, 32'(bus.txReady), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask
  task automatic frame(input logic [7:0] b, input logic par, input logic [7:0] nxt, input logic keep, input logic inj);
    logic [10:0] all_bits;
    logic [CPB-1:0] seen;
    int busy_n;
    all_bits = {1'b1, par, b, 1'b0};
    bus.txData = b;
    bus.txValid = 1'b1;
    tick;
    bus.txData = nxt;
    bus.txValid = keep;
    busy_n = 0;
    for (int k = 0; k < NB; k++) begin
      seen = '0;
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) tick;
        if (inj && k == 2 && c == 0) begin
          bus.txValid = 1'b1;
          bus.txData = 8'h55;
        end
        if (inj && k == 2 && c == 1) bus.txValid = 1'b0;
        seen[c] = tx;
        if (busy && !bus.txReady) busy_n++;
      end
      chk($sformatf("frame%02h_bit%0d", b, k), 32'(seen), 32'({CPB{k == NB - 1 ? 1'b1 : all_bits[k]}}));
    end
    chk($sformatf("frame%02h_busy_len", b), 32'(busy_n), 32'(L));
    tick;
    idle_chk($sformatf("frame%02h_gap", b));
  endtask
  initial begin
    int bad;
    bus.txValid = 1'b0;
    bus.txData = 8'h00;
    for (int i = 0; i < 3; i++) begin
      bus.txValid = 1'($urandom_range(0, 1));
      bus.txData = 8'($urandom);
      tick;
    end
    idle_chk("reset");
    bus.txValid = 1'b0;
    rstn = 1'b1;
    tick;
    tick;
    idle_chk("post_reset");
    frame(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
    frame(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(8'h07, 1'b1, 8'h00, 1'b0, 1'b0);
    frame(8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(8'hC3, 1'b0, 8'hC3, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      tick;
      if (busy || !tx || !bus.txReady) bad++;
    end
    chk("no_second_frame", 32'(bad), 32'd0);
    bus.txData = 8'h00;
    bus.txValid = 1'b1;
    tick;
    bus.txValid = 1'b0;
    repeat (17) tick;
    chk("mid_bit3_tx", 32'(tx), 32'd0);
    chk("mid_bit3_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    idle_chk("async_reset");
    tick;
    rstn = 1'b1;
    tick;
    idle_chk("after_abort");
    frame(8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
